// File: rtl/input_ports_pkg.sv
// Shared constants and helpers for the CPU input-port block.
// Port count, select width and default sizing live here so that the top level and the bench stay in step.
package input_ports_pkg;

   localparam int NPORTS          = 4;
   localparam int SEL_W           = 2;
   localparam int DEF_WIDTH       = 8;
   localparam int DEF_SYNC_STAGES = 2;

   typedef logic [SEL_W-1:0] port_sel_t;

   // One-hot strobe decode, the same shape as the output-port enable decoder.
   function automatic logic [NPORTS-1:0] decode_sel(input port_sel_t sel, input logic en);
      decode_sel      = '0;
      decode_sel[sel] = en;
   endfunction

endpackage

// File: rtl/input_ports_if.sv
// CPU-side bus of the input-port block: select/read strobe, interrupt-enable write, read data and status.
interface input_ports_if
   import input_ports_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   port_sel_t          sel;
   logic               rd;
   logic [WIDTH-1:0]   rdata;
   logic               ien_we;
   logic [NPORTS-1:0]  ien_wd;
   logic [NPORTS-1:0]  status;
   logic               irq;

   modport master (
      output sel, rd, ien_we, ien_wd,
      input  rdata, status, irq
   );

   modport slave (
      input  sel, rd, ien_we, ien_wd,
      output rdata, status, irq
   );

endinterface

// File: rtl/input_ports_in_port_sync.sv
// One external input port: synchronizer chain, capture register and "new data" flag.
// A capture on the same edge as a clearing read keeps the flag set, so fresh data is never hidden.
module in_port_sync
   import input_ports_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] ext_in,
   input  logic             clr,
   output logic [WIDTH-1:0] cap,
   output logic             new_flag
);

   // Fewer than two flops cannot be trusted against metastability.
   localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic [WIDTH-1:0] sync_q [STAGES];
   logic [WIDTH-1:0] sync_d [STAGES];
   logic [WIDTH-1:0] cap_q, cap_d;
   logic             new_q, new_d;
   logic             capture;

   always_comb begin
      sync_d[0] = ext_in;
      for (int i = 1; i < STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   always_comb begin
      capture = (sync_q[STAGES-1] != cap_q);
      cap_d   = capture ? sync_q[STAGES-1] : cap_q;
      new_d   = new_q;
      if (capture) begin
         new_d = 1'b1;
      end else if (clr) begin
         new_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_q[i] <= '0;
         end
         cap_q <= '0;
         new_q <= 1'b0;
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
         cap_q <= cap_d;
         new_q <= new_d;
      end
   end

   assign cap      = cap_q;
   assign new_flag = new_q;

endmodule

// File: rtl/input_ports.sv
// Input-side I/O block for the CPU: four synchronized input ports with new-data flags,
// a select/read path that clears the flag of the port being read, and a maskable interrupt.
module input_ports
   import input_ports_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  ext_in0,
   input  logic [WIDTH-1:0]  ext_in1,
   input  logic [WIDTH-1:0]  ext_in2,
   input  logic [WIDTH-1:0]  ext_in3,
   input_ports_if.slave      bus
);

   logic [WIDTH-1:0]  ext_arr [NPORTS];
   logic [WIDTH-1:0]  cap     [NPORTS];
   logic [NPORTS-1:0] clr;
   logic [NPORTS-1:0] new_flags;
   logic [NPORTS-1:0] ien_q, ien_d;

   assign ext_arr[0] = ext_in0;
   assign ext_arr[1] = ext_in1;
   assign ext_arr[2] = ext_in2;
   assign ext_arr[3] = ext_in3;

   assign clr = decode_sel(bus.sel, bus.rd);

   for (genvar i = 0; i < NPORTS; i++) begin : g_port
      in_port_sync #(
         .WIDTH       (WIDTH),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_port (
         .clk      (clk),
         .reset    (reset),
         .ext_in   (ext_arr[i]),
         .clr      (clr[i]),
         .cap      (cap[i]),
         .new_flag (new_flags[i])
      );
   end

   always_comb begin
      ien_d = ien_q;
      if (bus.ien_we) begin
         ien_d = bus.ien_wd;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ien_q <= '0;
      end else begin
         ien_q <= ien_d;
      end
   end

   // Read data reflects the pre-edge capture, even during a read that collides with a capture.
   assign bus.rdata  = cap[bus.sel];
   assign bus.status = new_flags;
   assign bus.irq    = |(new_flags & ien_q);

endmodule

// File: tb/tb_input_ports.sv
// Directed bench for input_ports: a table of one-cycle vectors plus hand-written
// sequences for reset release, read/capture collision and mid-operation reset.
module tb_input_ports;
   import input_ports_pkg::*;

   localparam int W = DEF_WIDTH;

   typedef struct {
      string        name;
      logic [W-1:0] e0, e1, e2, e3;
      logic [1:0]   sel;
      logic         rd;
      logic         ien_we;
      logic [3:0]   ien_wd;
      logic [W-1:0] exp_rdata;
      logic [3:0]   exp_status;
      logic         exp_irq;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] ext_in0, ext_in1, ext_in2, ext_in3;

   int checks   = 0;
   int failures = 0;

   vec_t vecs [20];

   input_ports_if #(.WIDTH(W)) bus ();

   input_ports #(
      .WIDTH       (W),
      .SYNC_STAGES (DEF_SYNC_STAGES)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .ext_in0 (ext_in0),
      .ext_in1 (ext_in1),
      .ext_in2 (ext_in2),
      .ext_in3 (ext_in3),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input vec_t v);
      ext_in0    = v.e0;
      ext_in1    = v.e1;
      ext_in2    = v.e2;
      ext_in3    = v.e3;
      bus.sel    = v.sel;
      bus.rd     = v.rd;
      bus.ien_we = v.ien_we;
      bus.ien_wd = v.ien_wd;
   endtask

   task automatic checkOutput(input string name, input logic [W-1:0] exp_rdata,
                              input logic [3:0] exp_status, input logic exp_irq);
      checks++;
      if (bus.rdata !== exp_rdata) begin
         failures++;
         $display("[TB] FAIL %s rdata: got %h expected %h", name, bus.rdata, exp_rdata);
      end
      checks++;
      if (bus.status !== exp_status) begin
         failures++;
         $display("[TB] FAIL %s status: got %b expected %b", name, bus.status, exp_status);
      end
      checks++;
      if (bus.irq !== exp_irq) begin
         failures++;
         $display("[TB] FAIL %s irq: got %b expected %b", name, bus.irq, exp_irq);
      end
   endtask

   initial begin
      // Starting point: port0 holds A5 with its flag cleared, other ports 0, ien 0.
      vecs[0]  = '{"cap2_e1",   8'hA5, 8'h00, 8'h3C, 8'h00, 2'd2, 1'b0, 1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0};
      vecs[1]  = '{"cap2_e2",   8'hA5, 8'h00, 8'h3C, 8'h00, 2'd2, 1'b0, 1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0};
      vecs[2]  = '{"cap2_e3",   8'hA5, 8'h00, 8'h3C, 8'h00, 2'd2, 1'b0, 1'b0, 4'b0000, 8'h3C, 4'b0100, 1'b0};
      vecs[3]  = '{"clr2",      8'hA5, 8'h00, 8'h3C, 8'h00, 2'd2, 1'b1, 1'b0, 4'b0000, 8'h3C, 4'b0000, 1'b0};
      vecs[4]  = '{"cap13_e1",  8'hA5, 8'h11, 8'h3C, 8'h33, 2'd1, 1'b0, 1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0};
      vecs[5]  = '{"cap13_e2",  8'hA5, 8'h11, 8'h3C, 8'h33, 2'd1, 1'b0, 1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0};
      vecs[6]  = '{"masked",    8'hA5, 8'h11, 8'h3C, 8'h33, 2'd1, 1'b0, 1'b0, 4'b0000, 8'h11, 4'b1010, 1'b0};
      vecs[7]  = '{"ien_wr",    8'hA5, 8'h11, 8'h3C, 8'h33, 2'd1, 1'b0, 1'b1, 4'b0010, 8'h11, 4'b1010, 1'b1};
      vecs[8]  = '{"rd1_irq",   8'hA5, 8'h11, 8'h3C, 8'h33, 2'd1, 1'b1, 1'b0, 4'b0000, 8'h11, 4'b1000, 1'b0};
      vecs[9]  = '{"sel3",      8'hA5, 8'h11, 8'h3C, 8'h33, 2'd3, 1'b0, 1'b0, 4'b0000, 8'h33, 4'b1000, 1'b0};
      vecs[10] = '{"rd3",       8'hA5, 8'h11, 8'h3C, 8'h33, 2'd3, 1'b1, 1'b0, 4'b0000, 8'h33, 4'b0000, 1'b0};
      vecs[11] = '{"rd0_noflag",8'hA5, 8'h11, 8'h3C, 8'h33, 2'd0, 1'b1, 1'b0, 4'b0000, 8'hA5, 4'b0000, 1'b0};
      vecs[12] = '{"all_e1",    8'h01, 8'h02, 8'h04, 8'h08, 2'd0, 1'b0, 1'b0, 4'b0000, 8'hA5, 4'b0000, 1'b0};
      vecs[13] = '{"all_e2",    8'h01, 8'h02, 8'h04, 8'h08, 2'd0, 1'b0, 1'b0, 4'b0000, 8'hA5, 4'b0000, 1'b0};
      vecs[14] = '{"all_e3",    8'h01, 8'h02, 8'h04, 8'h08, 2'd0, 1'b0, 1'b0, 4'b0000, 8'h01, 4'b1111, 1'b1};
      vecs[15] = '{"all_rd0",   8'h01, 8'h02, 8'h04, 8'h08, 2'd0, 1'b1, 1'b0, 4'b0000, 8'h01, 4'b1110, 1'b1};
      vecs[16] = '{"all_rd1",   8'h01, 8'h02, 8'h04, 8'h08, 2'd1, 1'b1, 1'b0, 4'b0000, 8'h02, 4'b1100, 1'b0};
      vecs[17] = '{"all_rd2",   8'h01, 8'h02, 8'h04, 8'h08, 2'd2, 1'b1, 1'b0, 4'b0000, 8'h04, 4'b1000, 1'b0};
      vecs[18] = '{"all_rd3",   8'h01, 8'h02, 8'h04, 8'h08, 2'd3, 1'b1, 1'b0, 4'b0000, 8'h08, 4'b0000, 1'b0};
      vecs[19] = '{"ien_all",   8'h01, 8'h02, 8'h04, 8'h08, 2'd0, 1'b0, 1'b1, 4'b1111, 8'h01, 4'b0000, 1'b0};

      reset      = 1'b0;
      ext_in0    = 8'hA5;
      ext_in1    = '0;
      ext_in2    = '0;
      ext_in3    = '0;
      bus.sel    = 2'd0;
      bus.rd     = 1'b0;
      bus.ien_we = 1'b0;
      bus.ien_wd = '0;

      #2;
      checkOutput("reset_hold", 8'h00, 4'b0000, 1'b0);
      @(negedge clk);
      checkOutput("reset_hold_clk", 8'h00, 4'b0000, 1'b0);

      reset = 1'b1;
      step();
      checkOutput("release_e1", 8'h00, 4'b0000, 1'b0);
      step();
      checkOutput("release_e2", 8'h00, 4'b0000, 1'b0);
      step();
      checkOutput("release_e3", 8'hA5, 4'b0001, 1'b0);
      bus.rd = 1'b1;
      step();
      checkOutput("release_clr", 8'hA5, 4'b0000, 1'b0);
      bus.rd = 1'b0;

      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i]);
         step();
         checkOutput(vecs[i].name, vecs[i].exp_rdata, vecs[i].exp_status, vecs[i].exp_irq);
      end

      // Read of port 1 lands on the same edge as its capture: the flag must survive.
      bus.ien_we = 1'b0;
      bus.rd     = 1'b0;
      bus.sel    = 2'd1;
      ext_in1    = 8'h77;
      step();
      checkOutput("coll_e1", 8'h02, 4'b0000, 1'b0);
      step();
      checkOutput("coll_e2", 8'h02, 4'b0000, 1'b0);
      bus.rd = 1'b1;
      #1;
      checkOutput("coll_pre", 8'h02, 4'b0000, 1'b0);
      step();
      checkOutput("coll_post", 8'h77, 4'b0010, 1'b1);
      step();
      checkOutput("coll_clr", 8'h77, 4'b0000, 1'b0);
      bus.rd = 1'b0;
      step();
      step();
      step();
      checkOutput("stable_no_reflag", 8'h77, 4'b0000, 1'b0);

      // Mid-operation reset drops pending flags and the interrupt enables.
      bus.sel = 2'd0;
      ext_in0 = 8'h10;
      ext_in1 = 8'h20;
      ext_in2 = 8'h40;
      ext_in3 = 8'h80;
      step();
      step();
      step();
      checkOutput("pending", 8'h10, 4'b1111, 1'b1);
      reset = 1'b0;
      #1;
      checkOutput("midreset_async", 8'h00, 4'b0000, 1'b0);
      step();
      reset = 1'b1;
      step();
      checkOutput("rerelease_e1", 8'h00, 4'b0000, 1'b0);
      step();
      checkOutput("rerelease_e2", 8'h00, 4'b0000, 1'b0);
      step();
      checkOutput("rerelease_e3", 8'h10, 4'b1111, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
